// File: rtl/lfsr_sched_if.sv
// lfsr_sched_if
// Purpose : bundles the requester-facing signals of the shared LFSR word
//           server so that consumers and the server connect through one
//           port.
// Signals :
//   req       - level request per requester (driven by consumers)
//   gnt       - registered one-hot grant pulse (driven by the server)
//   rnd_data  - delivered 16-bit word, valid while rnd_valid is high
//   rnd_valid - high exactly when gnt is non-zero
// Modports: master = requester side, slave = server side.
interface lfsr_sched_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [15:0]        rnd_data;
  logic               rnd_valid;

  modport master (output req, input gnt, input rnd_data, input rnd_valid);
  modport slave  (input req, output gnt, output rnd_data, output rnd_valid);
endinterface

// File: rtl/lfsr_sched.sv
// lfsr_sched
// Purpose : shared pseudo-random word server. One 16-bit maximal-length
//           Fibonacci LFSR (x^16+x^14+x^13+x^11+1) is seeded, optionally
//           warmed up, and then serves one word per cycle to NUM_REQ
//           requesters under round-robin arbitration. A step counter
//           flags each completed 65535-step period.
// Parameters:
//   NUM_REQ - number of requesters (2..8)
//   WARMUP  - LFSR steps discarded after every seed load (0..255)
// Ports   :
//   clk         - rising-edge clock
//   reset       - asynchronous active-high reset
//   seed_load   - single-cycle strobe; load seed and restart
//   seed        - seed value, sampled with seed_load (0 is loaded as 1)
//   bus         - lfsr_sched_if slave: req in; gnt, rnd_data, rnd_valid out
//   seeded      - high while serving words
//   period_done - one-cycle pulse when the step counter wraps 65534 -> 0
// Build option:
//   LFSR_SCHED_FREERUN_EN - when defined, the LFSR steps every serving
//   cycle regardless of requests; when undefined, it steps only on grants
//   so the delivered stream is exactly the LFSR sequence.
module lfsr_sched #(
  parameter int NUM_REQ = 4,
  parameter int WARMUP  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            seed_load,
  input  logic [15:0]     seed,
  lfsr_sched_if.slave     bus,
  output logic            seeded,
  output logic            period_done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_SERVE    = 2'd2
  } fsm_t;

  fsm_t               r_fsm;
  fsm_t               w_fsmNext;
  logic [15:0]        r_lfsr;
  logic [PTR_W-1:0]   r_rrPtr;
  logic [15:0]        r_stepCnt;
  logic [7:0]         r_warmCnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [15:0]        r_rndData;
  logic               r_rndValid;
  logic               r_periodDone;

  logic [15:0]        w_lfsrNext;
  logic [15:0]        w_seedClean;
  logic               w_grantHit;
  logic [PTR_W-1:0]   w_grantIdx;
  logic [PTR_W-1:0]   w_ptrNext;
  logic [NUM_REQ-1:0] w_grantOneHot;
  logic               w_step;
  logic               w_doGrant;

  // One Fibonacci step; an all-zero seed would lock the register, so it
  // is replaced by 1 on load.
  assign w_lfsrNext  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_seedClean = (seed == 16'h0000) ? 16'h0001 : seed;

  // Round-robin search: first look at requesters at or above the pointer,
  // then wrap around to the ones below it.
  always_comb begin
    w_grantHit    = 1'b0;
    w_grantIdx    = '0;
    w_grantOneHot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_grantHit && (j >= int'(r_rrPtr)) && bus.req[j]) begin
        w_grantHit = 1'b1;
        w_grantIdx = PTR_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_grantHit && (j < int'(r_rrPtr)) && bus.req[j]) begin
        w_grantHit = 1'b1;
        w_grantIdx = PTR_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grantHit && (PTR_W'(j) == w_grantIdx)) begin
        w_grantOneHot[j] = 1'b1;
      end
    end
  end

  // Pointer moves to just past the winner, wrapping at NUM_REQ (which need
  // not be a power of two).
  assign w_ptrNext = (w_grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : (w_grantIdx + 1'b1);

  // Next-state and step/grant decisions. A seed load wins over everything
  // else in the same cycle.
  always_comb begin
    w_fsmNext = r_fsm;
    w_step    = 1'b0;
    w_doGrant = 1'b0;
    if (seed_load) begin
      if (WARMUP > 0) begin
        w_fsmNext = ST_WARMUP;
      end else begin
        w_fsmNext = ST_SERVE;
      end
    end else begin
      case (r_fsm)
        ST_UNSEEDED: begin
          w_fsmNext = ST_UNSEEDED;
        end
        ST_WARMUP: begin
          w_step = 1'b1;
          if (r_warmCnt <= 8'd1) begin
            w_fsmNext = ST_SERVE;
          end
        end
        ST_SERVE: begin
          w_doGrant = w_grantHit;
`ifdef LFSR_SCHED_FREERUN_EN
          w_step    = 1'b1;
`else
          w_step    = w_grantHit;
`endif
        end
        default: begin
          w_fsmNext = ST_UNSEEDED;
        end
      endcase
    end
  end

  // State register for the controller.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm <= ST_UNSEEDED;
    end else begin
      r_fsm <= w_fsmNext;
    end
  end

  // Datapath: LFSR, step counter, warm-up counter, arbitration pointer and
  // the registered grant/word outputs. rnd_data only changes on a grant so
  // it keeps the last delivered word while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr       <= 16'h0001;
      r_rrPtr      <= '0;
      r_stepCnt    <= 16'h0000;
      r_warmCnt    <= 8'h00;
      r_gnt        <= '0;
      r_rndData    <= 16'h0000;
      r_rndValid   <= 1'b0;
      r_periodDone <= 1'b0;
    end else begin
      r_gnt        <= '0;
      r_rndValid   <= 1'b0;
      r_periodDone <= 1'b0;
      if (seed_load) begin
        r_lfsr    <= w_seedClean;
        r_stepCnt <= 16'h0000;
        r_warmCnt <= 8'(WARMUP);
      end else begin
        if (w_step) begin
          r_lfsr <= w_lfsrNext;
          // 65535 steps make one full period, so the count wraps at 65534.
          if (r_stepCnt == 16'hFFFE) begin
            r_stepCnt    <= 16'h0000;
            r_periodDone <= 1'b1;
          end else begin
            r_stepCnt <= r_stepCnt + 16'h0001;
          end
        end
        if (r_fsm == ST_WARMUP) begin
          r_warmCnt <= r_warmCnt - 8'd1;
        end
        if (w_doGrant) begin
          r_gnt      <= w_grantOneHot;
          r_rndData  <= r_lfsr;
          r_rndValid <= 1'b1;
          r_rrPtr    <= w_ptrNext;
        end
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rnd_data  = r_rndData;
  assign bus.rnd_valid = r_rndValid;
  assign seeded        = (r_fsm == ST_SERVE);
  assign period_done   = r_periodDone;

endmodule

// File: doc/lfsr_sched.md
Name: lfsr_sched

Overview:
- Shared pseudo-random word server built around one 16-bit maximal-length Fibonacci LFSR.
- Loads and sanitises the seed, runs an optional warm-up, then hands out one LFSR word per cycle to NUM_REQ requesters under round-robin arbitration.
- Tracks the step count and flags completion of one full 65535-step period.
- Sits between the seed source/configuration logic and multiple random-number consumers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WARMUP, 0, LFSR steps discarded after each seed load before serving (0..255).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- seed_load  input  1  single-cycle strobe; load seed and restart.
- seed  input  16  seed value, sampled when seed_load=1.
- req  input  NUM_REQ  level request per requester; 1 = wants a word this cycle.
- gnt  output  NUM_REQ  one-hot grant pulse, registered; marks the cycle rnd_data belongs to that requester.
- rnd_data  output  16  delivered word; valid when rnd_valid=1.
- rnd_valid  output  1  high exactly when gnt is non-zero.
- seeded  output  1  high while the FSM is in SERVE.
- period_done  output  1  one-cycle pulse when step_cnt wraps from 65534 to 0.

Behaviour:
- Reset, asynchronous:
  - state=16'h0001; FSM=UNSEEDED; rr_ptr=0; step_cnt=0; warm_cnt=0.
  - Outputs: gnt=0, rnd_data=0, rnd_valid=0, seeded=0, period_done=0.
- LFSR step:
  - Polynomial x^16+x^14+x^13+x^11+1.
  - fb = s[15]^s[13]^s[12]^s[10]; next = {s[14:0], fb}.
  - Sequence from 16'hACE1: ACE1 -> 59C3 -> B387.
- Seed sanitise: a seed of 16'h0000 is loaded as 16'h0001 (all-zero lock-up avoided).
- FSM states:
  - UNSEEDED: no steps, no grants. On seed_load, go to WARMUP if WARMUP>0, else SERVE.
  - WARMUP: steps every cycle and decrements warm_cnt (loaded with WARMUP on seed_load). No grants. When warm_cnt reaches 1, that step completes and FSM goes to SERVE.
  - SERVE: each cycle with req!=0, grant the first set req bit at or after rr_ptr (cyclic search). On the next edge: gnt=onehot, rnd_data=state, rnd_valid=1, state<=next, rr_ptr=granted index+1 mod NUM_REQ.
  - SERVE with req=0: gnt=0, rnd_valid=0, state holds.
- seed_load priority:
  - Accepted in any state; overrides grants in the same cycle (gnt=0, rnd_valid=0 on the following edge).
  - Reloads state and resets step_cnt=0.
  - rr_ptr is not changed.
- Latency: req sampled at edge k gives gnt/rnd_data valid during cycle k+1. A requester holding req continuously is granted in rotation; a sole requester gets a word every cycle.
- Delivered sequence: the first word after seeding (WARMUP=0) is the sanitised seed itself. Each word is delivered exactly once; no word is duplicated or skipped across requesters.
- step_cnt (16-bit):
  - Increments on every LFSR step, warm-up steps included.
  - On the step that takes it from 65534, it becomes 0 and period_done pulses for one cycle.
  - After exactly 65535 steps, state equals the post-load value.
- Reset mid-operation: returns to UNSEEDED immediately; a pending grant is dropped.
- rnd_data holds its last value while rnd_valid=0.

Optional Feature:
- Macro: LFSR_SCHED_FREERUN_EN.
- Defined: in SERVE the LFSR steps every cycle regardless of req. The word delivered on a grant is the state at the sampling edge, so consumers observe a timing-dependent subsequence. step_cnt and period_done follow the free-running steps.
- Undefined (default): the LFSR steps only on grants, so the concatenated delivered stream is the exact LFSR sequence.

Test Plan:
- Reset asserted, then seed_load with seed=16'hACE1, then req=4'b0001 held 3 cycles -> gnt=0001 each cycle; rnd_data=ACE1, 59C3, B387; rnd_valid=1; seeded=1.
- Seed 16'hACE1, req=4'b1111 held 5 cycles -> gnt 0001, 0010, 0100, 1000, 0001; rnd_data ACE1, 59C3, B387, then the next two LFSR words in order.
- seed_load with seed=16'h0000, then req=4'b0010 -> first rnd_data=16'h0001, second 16'h0002; no lock-up.
- WARMUP=2, seed 16'hACE1, req held -> no gnt for the 2 warm-up cycles; first rnd_data=16'hB387.
- req=4'b0001 held for 65535 grants after seeding 16'hACE1 -> period_done pulses once, on the 65535th step. The next delivered word is 16'hACE1 and no word is 16'h0000.
- seed_load and req=4'b0100 in the same cycle mid-stream; separately, reset asserted mid-grant -> no grant on the seed_load cycle and the next word is the new seed. Reset gives all outputs 0 and seeded=0 immediately, with no clock edge needed.
